// File: rtl/ws2812_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_word_receiver
// Description : Serial-to-parallel decoder for the single-wire LED data
//               waveform. Each bit is a high pulse followed by low time;
//               a long high decodes as 1 and a short high as 0, MSB first.
//               A long low period marks the frame (latch) gap. Decoding only
//               starts after a full gap, so a mid-frame start-up is ignored.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               en         - decoder enable; 0 holds the block in SYNC
//               din        - asynchronous serial data line
//               out        - last complete word, MSB = first received bit
//               valid      - one-cycle pulse when out is updated
//               frame_end  - one-cycle pulse when a gap completes after activity
//               err        - one-cycle pulse on a protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_word_receiver #(
    parameter int W         = 24,
    parameter int CNT_W     = 9,
    parameter int MIN_HIGH  = 4,
    parameter int HIGH_THR  = 18,
    parameter int MAX_HIGH  = 40,
    parameter int RESET_LOW = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] out,
    output logic         valid,
    output logic         frame_end,
    output logic         err
);

    localparam int c_BC_W = $clog2(W + 1);

    localparam logic [1:0] c_ST_SYNC = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;
    localparam logic [1:0] c_ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
    // The gap fires on the cycle whose count would reach RESET_LOW.
    localparam logic [CNT_W-1:0]  c_GAP_LAST = CNT_W'(RESET_LOW - 1);
    localparam logic [CNT_W-1:0]  c_MIN_HIGH = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]  c_HIGH_THR = CNT_W'(HIGH_THR);
    localparam logic [CNT_W-1:0]  c_MAX_HIGH = CNT_W'(MAX_HIGH);
    localparam logic [c_BC_W-1:0] c_LAST_BIT = c_BC_W'(W - 1);
    localparam logic [c_BC_W-1:0] c_BC_ONE   = c_BC_W'(1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_din_prev;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [W-1:0]      r_shreg;
    logic [c_BC_W-1:0] r_bit_cnt;
    logic [W-1:0]      r_out;
    logic              r_valid;
    logic              r_frame_end;
    logic              r_err;

    logic              w_din_s;
    logic              w_rise;
    logic              w_bit;
    logic [W-1:0]      w_shifted;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [W-1:0]      w_shreg_nxt;
    logic [c_BC_W-1:0] w_bit_cnt_nxt;
    logic [W-1:0]      w_out_nxt;
    logic              w_valid_nxt;
    logic              w_frame_end_nxt;
    logic              w_err_nxt;

    assign w_din_s   = r_sync2;
    assign w_rise    = w_din_s & ~r_din_prev;
    // In HIGH on the falling-edge cycle r_cnt holds the pulse length.
    assign w_bit     = (r_cnt >= c_HIGH_THR);
    assign w_shifted = {r_shreg[W-2:0], w_bit};
    // Saturating increment so a stuck line can never wrap the counter.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

    // State register
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_state <= c_ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_SYNC: begin
                if (!w_din_s && r_cnt == c_GAP_LAST) w_state_nxt = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                if (w_rise) w_state_nxt = c_ST_HIGH;
            end
            c_ST_HIGH: begin
                if (w_din_s) begin
                    if (r_cnt >= c_MAX_HIGH) w_state_nxt = c_ST_SYNC;
                end else if (r_cnt < c_MIN_HIGH) begin
                    w_state_nxt = c_ST_SYNC;
                end else begin
                    w_state_nxt = c_ST_LOW;
                end
            end
            c_ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt = c_ST_HIGH;
                end else if (!w_din_s && r_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_SYNC;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_out_nxt       = r_out;
        w_valid_nxt     = 1'b0;
        w_frame_end_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            c_ST_SYNC: begin
                if (w_din_s || r_cnt == c_GAP_LAST) w_cnt_nxt = '0;
                else                                w_cnt_nxt = w_cnt_inc;
            end
            c_ST_IDLE: begin
                if (w_rise) w_cnt_nxt = c_CNT_ONE;
            end
            c_ST_HIGH: begin
                if (w_din_s) begin
                    if (r_cnt >= c_MAX_HIGH) begin
                        w_err_nxt     = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (r_cnt < c_MIN_HIGH) begin
                    w_err_nxt     = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_cnt_nxt     = '0;
                end else begin
                    // The falling-edge cycle is the first low cycle.
                    w_shreg_nxt = w_shifted;
                    w_cnt_nxt   = c_CNT_ONE;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_out_nxt     = w_shifted;
                        w_valid_nxt   = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_BC_ONE;
                    end
                end
            end
            c_ST_LOW: begin
                if (w_rise) begin
                    w_cnt_nxt = c_CNT_ONE;
                end else if (!w_din_s) begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_frame_end_nxt = 1'b1;
                        w_cnt_nxt       = '0;
                        // A gap inside a word drops the partial word.
                        if (r_bit_cnt != '0) begin
                            w_err_nxt     = 1'b1;
                            w_bit_cnt_nxt = '0;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    // Synchronizer and datapath registers. Disabling behaves like reset
    // except that the last reported word is kept.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_din_prev  <= 1'b0;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_err       <= 1'b0;
            if (rst) r_out <= '0;
        end else begin
            r_sync1     <= din;
            r_sync2     <= r_sync1;
            r_din_prev  <= r_sync2;
            r_cnt       <= w_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_out       <= w_out_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_end <= w_frame_end_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign out       = r_out;
    assign valid     = r_valid;
    assign frame_end = r_frame_end;
    assign err       = r_err;

endmodule
`default_nettype wire
